// File: rtl/mmio_fifo_bank.sv
// mmio_fifo_bank: a bank of NUM_CH independent FIFOs reachable over CCI-P MMIO.
// For each channel i there are two registers:
//   DATA(i) = BASE_ADDR + 4*i      write pushes a word, read pops one
//   STAT(i) = BASE_ADDR + 4*i + 2  read gives {uf, ovf, full, empty, count},
//                                  write-1-to-clear the sticky ovf/uf flags
// A read response leaves one cycle after a decoded read request.
// Addresses outside the map are ignored and produce no response.
module mmio_fifo_bank #(
  parameter int          DATA_W    = 64,
  parameter int          DEPTH     = 8,
  parameter int          NUM_CH    = 2,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [63:0]       mmio_wdata,
  output logic              rd_rsp_valid,
  output logic [8:0]        rd_rsp_tid,
  output logic [63:0]       rd_rsp_data,
  output logic [NUM_CH-1:0] fifo_empty,
  output logic [NUM_CH-1:0] fifo_full
);

  // Width of the occupancy counter (must hold DEPTH) and of the pointers.
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // STAT bit positions that the W1C write acts on.
  localparam int OVF_CLR_BIT = 18;
  localparam int UF_CLR_BIT  = 19;

  // Word address of the DATA register of channel ch.
  function automatic logic [15:0] data_addr(input int ch);
    return BASE_ADDR + 16'(4 * ch);
  endfunction

  // Word address of the STAT register of channel ch.
  function automatic logic [15:0] stat_addr(input int ch);
    return BASE_ADDR + 16'(4 * ch + 2);
  endfunction

  // Pointer increment. It wraps from DEPTH-1 to 0, so DEPTH need not be a
  // power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
  endfunction

  // Storage.
  logic [DATA_W-1:0] mem_q [NUM_CH][DEPTH];

  // Per-channel state.
  logic [NUM_CH-1:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [NUM_CH-1:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [NUM_CH-1:0][CW-1:0] count_q, count_d;
  logic [NUM_CH-1:0]         ovf_q, ovf_d;
  logic [NUM_CH-1:0]         uf_q, uf_d;
  logic [NUM_CH-1:0]         empty_q, empty_d;
  logic [NUM_CH-1:0]         full_q, full_d;

  // Read response registers.
  logic        rsp_valid_q, rsp_valid_d;
  logic [8:0]  rsp_tid_q, rsp_tid_d;
  logic [63:0] rsp_data_q, rsp_data_d;

  // Per-channel address decode results and the resulting push/pop enables.
  logic [NUM_CH-1:0] wr_data_hit, wr_stat_hit;
  logic [NUM_CH-1:0] rd_data_hit, rd_stat_hit;
  logic [NUM_CH-1:0] push_ok, pop_ok;

  // Decode the shared MMIO address against the register map of every channel.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    //       code. This way no path can leave a signal unassigned and infer a latch.
    wr_data_hit = '0;
    wr_stat_hit = '0;
    rd_data_hit = '0;
    rd_stat_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_data_hit[i] = mmio_wr_valid && (mmio_addr == data_addr(i));
      wr_stat_hit[i] = mmio_wr_valid && (mmio_addr == stat_addr(i));
      rd_data_hit[i] = mmio_rd_valid && (mmio_addr == data_addr(i));
      rd_stat_hit[i] = mmio_rd_valid && (mmio_addr == stat_addr(i));
    end
  end

  // Next state of the FIFO and the flags, plus the response to the read.
  // Every read is computed from the state before this cycle.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    uf_d        = uf_q;
    empty_d     = empty_q;
    full_d      = full_q;
    push_ok     = '0;
    pop_ok      = '0;
    rsp_valid_d = 1'b0;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;

    for (int i = 0; i < NUM_CH; i++) begin
      // A pop on a full FIFO frees a slot for a push in the same cycle, so
      // the push does not count as an overflow.
      pop_ok[i]  = rd_data_hit[i] && (count_q[i] != '0);
      push_ok[i] = wr_data_hit[i] && ((count_q[i] != DEPTH_C) || pop_ok[i]);

      if (push_ok[i]) wr_ptr_d[i] = next_ptr(wr_ptr_q[i]);
      if (pop_ok[i])  rd_ptr_d[i] = next_ptr(rd_ptr_q[i]);

      count_d[i] = count_q[i] + CW'(push_ok[i]) - CW'(pop_ok[i]);

      // Sticky flags. If a flag is set and cleared in the same cycle, the
      // set has priority.
      ovf_d[i] = (wr_data_hit[i] && !push_ok[i]) ||
                 (ovf_q[i] && !(wr_stat_hit[i] && mmio_wdata[OVF_CLR_BIT]));
      uf_d[i]  = (rd_data_hit[i] && !pop_ok[i]) ||
                 (uf_q[i] && !(wr_stat_hit[i] && mmio_wdata[UF_CLR_BIT]));

      empty_d[i] = (count_d[i] == '0);
      full_d[i]  = (count_d[i] == DEPTH_C);

      if (rd_data_hit[i]) begin
        rsp_valid_d = 1'b1;
        rsp_tid_d   = mmio_tid;
        rsp_data_d  = pop_ok[i] ? 64'(mem_q[i][rd_ptr_q[i]]) : 64'd0;
      end

      if (rd_stat_hit[i]) begin
        rsp_valid_d = 1'b1;
        rsp_tid_d   = mmio_tid;
        rsp_data_d  = {44'd0, uf_q[i], ovf_q[i], full_q[i], empty_q[i],
                       16'(count_q[i])};
      end
    end
  end

  // Register the control state and the response. Reset overrides any request
  // arriving in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    //       samples the values from before the clock edge.
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= '0;
      uf_q        <= '0;
      empty_q     <= '1;
      full_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      uf_q        <= uf_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Write pushed words into storage at the write pointer of their channel.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset. The reset pointers and counts make the
    //       stale contents unreachable, so the memory can map to plain RAM.
    for (int i = 0; i < NUM_CH; i++) begin
      if (!rst && push_ok[i]) mem_q[i][wr_ptr_q[i]] <= mmio_wdata[DATA_W-1:0];
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_tid   = rsp_tid_q;
  assign rd_rsp_data  = rsp_data_q;
  assign fifo_empty   = empty_q;
  assign fifo_full    = full_q;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Self-checking bench for mmio_fifo_bank. The bench holds one queue per
// channel as its reference model. Directed steps follow the intended usage,
// and a randomized phase comes after them.
module tb_mmio_fifo_bank;

  localparam int          DATA_W = 64;
  localparam int          DEPTH  = 8;
  localparam int          NUM_CH = 2;
  localparam logic [15:0] BASE   = 16'h0020;

  logic              clk = 1'b0;
  logic              rst;
  logic              mmio_wr_valid;
  logic              mmio_rd_valid;
  logic [15:0]       mmio_addr;
  logic [8:0]        mmio_tid;
  logic [63:0]       mmio_wdata;
  logic              rd_rsp_valid;
  logic [8:0]        rd_rsp_tid;
  logic [63:0]       rd_rsp_data;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;

  always #5 clk = ~clk;

  mmio_fifo_bank #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_tid(rd_rsp_tid),
    .rd_rsp_data(rd_rsp_data),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: contents of each FIFO, sticky flags, last response.
  logic [63:0] mq [NUM_CH][$];
  logic        ovf_m [NUM_CH];
  logic        uf_m  [NUM_CH];
  logic [8:0]  last_tid;
  logic [63:0] last_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] stat_word(input int ch);
    int n;
    n = mq[ch].size();
    return {44'd0, uf_m[ch], ovf_m[ch], (n == DEPTH), (n == 0), 16'(n)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mq[i].delete();
      ovf_m[i] = 1'b0;
      uf_m[i]  = 1'b0;
    end
    last_tid  = '0;
    last_data = '0;
  endtask

  task automatic check_outputs(input string tag, input logic exp_valid);
    logic [NUM_CH-1:0] exp_empty, exp_full;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_empty[i] = (mq[i].size() == 0);
      exp_full[i]  = (mq[i].size() == DEPTH);
    end
    check({tag, ".valid"}, 64'(rd_rsp_valid), 64'(exp_valid));
    check({tag, ".tid"},   64'(rd_rsp_tid),   64'(last_tid));
    check({tag, ".data"},  rd_rsp_data,       last_data);
    check({tag, ".empty"}, 64'(fifo_empty),   64'(exp_empty));
    check({tag, ".full"},  64'(fifo_full),    64'(exp_full));
  endtask

  // One MMIO cycle. The model is updated from the same request, and then
  // the registered outputs are compared after the edge.
  task automatic step(input string tag, input logic wr, input logic rd,
                      input logic [15:0] addr, input logic [63:0] wdata,
                      input logic [8:0] tid);
    int ch, kind, off;
    logic exp_valid;
    ch = -1;
    kind = -1;
    off = int'(addr) - int'(BASE);
    if (off >= 0 && off < 4 * NUM_CH && (off % 4 == 0 || off % 4 == 2)) begin
      ch   = off / 4;
      kind = off % 4;
    end
    exp_valid = 1'b0;
    if (rd && ch >= 0) begin
      exp_valid = 1'b1;
      last_tid  = tid;
      if (kind == 2)               last_data = stat_word(ch);
      else if (mq[ch].size() > 0)  last_data = mq[ch].pop_front();
      else begin
        last_data = '0;
        uf_m[ch]  = 1'b1;
      end
    end
    if (wr && ch >= 0) begin
      if (kind == 0) begin
        if (mq[ch].size() < DEPTH) mq[ch].push_back(wdata);
        else                       ovf_m[ch] = 1'b1;
      end else begin
        if (wdata[18]) ovf_m[ch] = 1'b0;
        if (wdata[19]) uf_m[ch]  = 1'b0;
      end
    end

    @(negedge clk);
    mmio_wr_valid = wr;
    mmio_rd_valid = rd;
    mmio_addr     = addr;
    mmio_wdata    = wdata;
    mmio_tid      = tid;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    check_outputs(tag, exp_valid);
  endtask

  // Reset for one cycle, optionally with a read to DATA(0) in the same cycle.
  task automatic pulse_reset(input logic with_read);
    @(negedge clk);
    rst           = 1'b1;
    mmio_rd_valid = with_read;
    mmio_addr     = BASE;
    mmio_tid      = 9'h1AB;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    mmio_rd_valid = 1'b0;
    model_reset();
    check_outputs("reset", 1'b0);
  endtask

  initial begin
    logic [15:0] addrs [8];
    rst           = 1'b1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    mmio_addr     = '0;
    mmio_tid      = '0;
    mmio_wdata    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    pulse_reset(1'b0);

    // Status of an empty channel, then a read to an undecoded address.
    step("stat0", 1'b0, 1'b1, 16'h0022, 64'd0, 9'h5);
    check("stat0_const", rd_rsp_data, 64'h10000);
    check("stat0_tid", 64'(rd_rsp_tid), 64'h5);
    step("undecoded", 1'b0, 1'b1, 16'h0010, 64'd0, 9'h6);

    // Basic ordering on channel 0. Channel 1 must stay untouched.
    step("push_a1", 1'b1, 1'b0, 16'h0020, 64'hA1, 9'h0);
    step("push_a2", 1'b1, 1'b0, 16'h0020, 64'hA2, 9'h0);
    step("push_a3", 1'b1, 1'b0, 16'h0020, 64'hA3, 9'h0);
    step("stat0_3", 1'b0, 1'b1, 16'h0022, 64'd0, 9'h7);
    check("stat0_3_const", rd_rsp_data, 64'h3);
    for (int k = 0; k < 3; k++) begin
      step("pop_a", 1'b0, 1'b1, 16'h0020, 64'd0, 9'(k + 16));
      check("pop_a_const", rd_rsp_data, 64'hA1 + 64'(k));
      step("stat1_idle", 1'b0, 1'b1, 16'h0026, 64'd0, 9'h8);
      check("stat1_idle_const", rd_rsp_data, 64'h10000);
    end

    // Overflow on channel 1.
    for (int k = 0; k < 9; k++)
      step("push_ch1", 1'b1, 1'b0, 16'h0024, 64'h100 + 64'(k), 9'h0);
    check("ch1_full_const", 64'(fifo_full), 64'b10);
    step("stat1_ovf", 1'b0, 1'b1, 16'h0026, 64'd0, 9'h9);
    check("stat1_ovf_const", rd_rsp_data, 64'h60008);
    for (int k = 0; k < 8; k++) begin
      step("pop_ch1", 1'b0, 1'b1, 16'h0024, 64'd0, 9'h0A);
      check("pop_ch1_const", rd_rsp_data, 64'h100 + 64'(k));
    end
    step("clr_ovf1", 1'b1, 1'b0, 16'h0026, 64'h40000, 9'h0);
    step("stat1_clr", 1'b0, 1'b1, 16'h0026, 64'd0, 9'h0B);
    check("stat1_clr_const", rd_rsp_data, 64'h10000);

    // Underflow, then a push and a pop in the same cycle on an empty channel.
    step("pop_empty", 1'b0, 1'b1, 16'h0020, 64'd0, 9'h0C);
    check("pop_empty_const", rd_rsp_data, 64'h0);
    step("stat0_uf", 1'b0, 1'b1, 16'h0022, 64'd0, 9'h0D);
    check("stat0_uf_const", rd_rsp_data, 64'h90000);
    step("pushpop_empty", 1'b1, 1'b1, 16'h0020, 64'h77, 9'h0E);
    check("pushpop_empty_const", rd_rsp_data, 64'h0);
    step("pop_77", 1'b0, 1'b1, 16'h0020, 64'd0, 9'h0F);
    check("pop_77_const", rd_rsp_data, 64'h77);
    // Read STAT and clear uf in the same cycle: the read shows the flag before the clear.
    step("stat_w1c", 1'b1, 1'b1, 16'h0022, 64'h80000, 9'h10);
    check("stat_w1c_const", rd_rsp_data, 64'h90000);

    // Push and pop in the same cycle while full, across pointer wrap.
    for (int k = 0; k < 8; k++)
      step("fill0", 1'b1, 1'b0, 16'h0020, 64'hC0 + 64'(k), 9'h0);
    step("pushpop_full", 1'b1, 1'b1, 16'h0020, 64'hBB, 9'h11);
    check("pushpop_full_const", rd_rsp_data, 64'hC0);
    step("stat0_full", 1'b0, 1'b1, 16'h0022, 64'd0, 9'h12);
    check("stat0_full_const", rd_rsp_data, 64'h20008);
    for (int k = 0; k < 20; k++)
      step("wrap", 1'b1, 1'b1, 16'h0020, 64'hD00 + 64'(k), 9'(k));
    for (int k = 0; k < 8; k++)
      step("drain0", 1'b0, 1'b1, 16'h0020, 64'd0, 9'h13);
    check("drain0_last_const", rd_rsp_data, 64'hD13);

    // Reset with a read in the same cycle: the read is dropped and the state clears.
    for (int k = 0; k < 3; k++)
      step("pre_rst", 1'b1, 1'b0, 16'h0020, 64'hE0 + 64'(k), 9'h0);
    pulse_reset(1'b1);
    step("post_rst_idle", 1'b0, 1'b0, 16'h0020, 64'd0, 9'h0);
    step("post_rst_stat", 1'b0, 1'b1, 16'h0022, 64'd0, 9'h14);
    check("post_rst_const", rd_rsp_data, 64'h10000);

    // Randomized traffic over decoded and undecoded addresses.
    addrs = '{16'h0020, 16'h0022, 16'h0024, 16'h0026,
              16'h0021, 16'h0023, 16'h0028, 16'h0010};
    for (int k = 0; k < 500; k++) begin
      logic [15:0] a;
      logic        w, r;
      a = addrs[$urandom_range(0, (k % 5 == 0) ? 7 : 3)];
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      step("rand", w, r, a, {$urandom, $urandom}, 9'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_bank.md
Name: mmio_fifo_bank

Overview:
- Parametrised bank of NUM_CH independent FIFOs, each reachable through MMIO.
- An MMIO write to a channel's data address pushes a word; an MMIO read from the same address pops one.
- Each channel has a status/control register with occupancy, full/empty flags and sticky overflow/underflow flags (write-1-to-clear).
- Sits inside the AFU between the CCI-P MMIO decode (header already cast to address/tid) and the tx.c2 read-response mux.

Parameters:
- DATA_W, 64: FIFO word width. Must be ≤ 64; read data is zero-extended to 64 bits.
- DEPTH, 8: entries per channel. Must be ≥ 2; need not be a power of 2.
- NUM_CH, 2: number of channels, 1..16.
- BASE_ADDR, 16'h0020: MMIO word address of channel 0 data register.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mmio_wr_valid  in  1  MMIO write request strobe (rx.c0.mmioWrValid)
- mmio_rd_valid  in  1  MMIO read request strobe (rx.c0.mmioRdValid)
- mmio_addr  in  16  MMIO word address
- mmio_tid  in  9  read transaction ID
- mmio_wdata  in  64  write data
- rd_rsp_valid  out  1  read response valid
- rd_rsp_tid  out  9  tid echoed with the response
- rd_rsp_data  out  64  response data
- fifo_empty  out  NUM_CH  per-channel empty flag, registered
- fifo_full  out  NUM_CH  per-channel full flag, registered

Behaviour:
- Address map, for channel i: DATA = BASE_ADDR + 4*i; STAT = BASE_ADDR + 4*i + 2. All other addresses are not decoded by this block.
- Reset is synchronous on rst.
  - Clears all read/write pointers, counts, and sticky flags.
  - Drives rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0, fifo_empty=all 1s, fifo_full=all 0s.
  - A request in the same cycle as rst is ignored.
  - A pending response is discarded.
  - FIFO storage contents need not be reset.
- Write to DATA(i):
  - If not full: store mmio_wdata[DATA_W-1:0] at the write pointer, advance the pointer (wraps DEPTH-1 → 0), count+1.
  - If full: drop the word and set ovf[i].
- Write to STAT(i): wdata[18]=1 clears ovf[i]; wdata[19]=1 clears uf[i]. Other bits are ignored.
- Read from DATA(i):
  - If not empty: return the head word zero-extended to 64 bits, advance the read pointer (wraps), count-1.
  - If empty: return 0 and set uf[i].
- Read from STAT(i): returns {44'b0, uf, ovf, full, empty, count[15:0]}, with count zero-extended from $clog2(DEPTH+1) bits.
- Read latency:
  - rd_rsp_valid pulses high exactly 1 cycle after a decoded mmio_rd_valid, with rd_rsp_tid = mmio_tid of that request.
  - A read to an undecoded address produces no response and has no side effects.
  - rd_rsp_valid is otherwise 0.
  - rd_rsp_data and rd_rsp_tid hold their last values when rd_rsp_valid=0.
- Simultaneous mmio_wr_valid and mmio_rd_valid are both processed.
  - Push and pop on the same channel: the pop observes pre-cycle state.
    - Not empty: pop returns the old head, push stores, count unchanged.
    - Full: both succeed, count stays DEPTH, no ovf.
    - Empty: pop returns 0 and sets uf; push succeeds, count=1.
  - A pop on STAT(i) together with a W1C write to STAT(i): the read returns the pre-clear flags, then the flags clear.
  - Overflow or underflow in the same cycle as a W1C of that flag: set wins.
- Flags: fifo_empty/fifo_full reflect post-update count, registered, visible the cycle after the operation.
- Channels are fully independent; an operation on channel i never changes channel j state.

Test Plan:
- Reset, then read STAT(0) at 0x0022 with tid=9'h5 → rd_rsp_valid next cycle, tid 5, data 0x10000 (empty=1, count=0). Read addr 0x0010 → no response.
- Push 0xA1, 0xA2, 0xA3 to 0x0020, then pop three times from 0x0020 → data 0xA1, 0xA2, 0xA3 in order. STAT(0) count steps 3→0. Channel 1 STAT at 0x0026 stays 0x10000 throughout.
- DEPTH=8: push 9 words to channel 1 (0x0024) → 9th dropped, fifo_full[1]=1, STAT bit18=1, count=8. Pop 8 → returns the first 8 words. Write 0x40000 to 0x0026 → ovf cleared.
- Pop empty channel 0 → data 0, uf set (STAT bit19=1). Same-cycle push 0x77 and pop on empty channel 0 → pop returns 0, count=1, next pop returns 0x77.
- Fill channel 0 to 8 entries; same-cycle push 0xBB and pop → old head returned, count stays 8, no ovf. Drain and check 0xBB arrives last. Repeat across pointer wrap (≥20 cycles of push/pop).
- Push 3 words, assert rst for 1 cycle with a concurrent mmio_rd_valid to 0x0020 → no response, STAT(0) reads 0x10000 afterwards.
